// File: rtl/dp_issue.sv
// dp_issue: sequential decode-and-issue unit for ARM data-processing
// instructions. Takes one instruction per handshake, reads Rn/Rm from the
// register file, checks the condition code and runs the barrel shifter. It
// then drives the downstream combinational ALU, writes Rd back and owns the
// CPSR NZCV flags.
//
// Ports:
//   clk, rst_n                  clock (rising edge) / async active-low reset
//   instr_valid/instr/instr_ready   instruction handshake (ready only in IDLE)
//   rn_addr/rn_data, rm_addr/rm_data combinational register-file reads
//   alu_opcode/operand1/operand2/carry_in/flag_update   ALU drive
//   alu_result, alu_n/z/c/v     ALU return
//   rd_we/rd_addr/rd_data       one-cycle writeback strobe and payload
//   cpsr_nzcv                   {N,Z,C,V}
//   cond_fail, undef            one-cycle status pulses
module dp_issue (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        instr_valid,
  input  logic [31:0] instr,
  output logic        instr_ready,
  output logic [3:0]  rn_addr,
  input  logic [31:0] rn_data,
  output logic [3:0]  rm_addr,
  input  logic [31:0] rm_data,
  output logic [3:0]  alu_opcode,
  output logic [31:0] alu_operand1,
  output logic [31:0] alu_operand2,
  output logic        alu_carry_in,
  output logic        alu_flag_update,
  input  logic [31:0] alu_result,
  input  logic        alu_n,
  input  logic        alu_z,
  input  logic        alu_c,
  input  logic        alu_v,
  output logic        rd_we,
  output logic [3:0]  rd_addr,
  output logic [31:0] rd_data,
  output logic [3:0]  cpsr_nzcv,
  output logic        cond_fail,
  output logic        undef
);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_EXEC} state_e;

  state_e      state_q, state_d;
  logic [31:0] ir_q, ir_d;
  logic [31:0] op1_q, op1_d;
  logic [31:0] op2_q, op2_d;
  logic        sh_c_q, sh_c_d;
  logic [31:0] rd_data_q, rd_data_d;
  logic        rd_we_q, rd_we_d;
  logic        cond_fail_q, cond_fail_d;
  logic        undef_q, undef_d;
  logic [3:0]  cpsr_q, cpsr_d;

  logic f_n, f_z, f_c, f_v;
  assign {f_n, f_z, f_c, f_v} = cpsr_q;

  // Decoded fields come straight off the instruction register, which is
  // stable from READ through the following IDLE cycle.
  assign instr_ready     = (state_q == S_IDLE);
  assign rn_addr         = ir_q[19:16];
  assign rm_addr         = ir_q[3:0];
  assign rd_addr         = ir_q[15:12];
  assign alu_opcode      = ir_q[24:21];
  assign alu_flag_update = ir_q[20];
  assign alu_operand1    = op1_q;
  assign alu_operand2    = op2_q;
  assign alu_carry_in    = f_c;
  assign rd_we           = rd_we_q;
  assign rd_data         = rd_data_q;
  assign cpsr_nzcv       = cpsr_q;
  assign cond_fail       = cond_fail_q;
  assign undef           = undef_q;

  // Condition evaluation against the current CPSR.
  logic cond_pass;
  always_comb begin
    cond_pass = 1'b0;
    case (ir_q[31:28])
      4'h0: cond_pass = f_z;
      4'h1: cond_pass = !f_z;
      4'h2: cond_pass = f_c;
      4'h3: cond_pass = !f_c;
      4'h4: cond_pass = f_n;
      4'h5: cond_pass = !f_n;
      4'h6: cond_pass = f_v;
      4'h7: cond_pass = !f_v;
      4'h8: cond_pass = f_c && !f_z;
      4'h9: cond_pass = !f_c || f_z;
      4'hA: cond_pass = (f_n == f_v);
      4'hB: cond_pass = (f_n != f_v);
      4'hC: cond_pass = !f_z && (f_n == f_v);
      4'hD: cond_pass = f_z || (f_n != f_v);
      4'hE: cond_pass = 1'b1;
      default: cond_pass = 1'b0;
    endcase
  end

  // Barrel shifter. The LSR/ASR paths shift Rm with a guard bit appended so
  // the last bit shifted out lands in bit 0; LSL keeps a guard bit on top.
  logic [4:0]  amt, rot;
  logic [31:0] imm32, ror_w, sh_res;
  logic [32:0] lsl_w, lsr_w, asr_w;
  logic        sh_c;
  always_comb begin
    amt    = ir_q[11:7];
    rot    = {ir_q[11:8], 1'b0};
    imm32  = {24'b0, ir_q[7:0]};
    lsl_w  = {1'b0, rm_data} << amt;
    lsr_w  = {rm_data, 1'b0} >> amt;
    asr_w  = $signed({rm_data, 1'b0}) >>> amt;
    ror_w  = (rm_data >> amt) | (rm_data << (5'd0 - amt));
    sh_res = rm_data;
    sh_c   = f_c;
    if (ir_q[25]) begin
      sh_res = (imm32 >> rot) | (imm32 << (5'd0 - rot));
      sh_c   = (rot == 5'd0) ? f_c : sh_res[31];
    end else begin
      case (ir_q[6:5])
        2'b00: if (amt != 5'd0) begin
          sh_res = lsl_w[31:0];
          sh_c   = lsl_w[32];
        end
        2'b01: if (amt == 5'd0) begin  // LSR #32
          sh_res = 32'b0;
          sh_c   = rm_data[31];
        end else begin
          sh_res = lsr_w[32:1];
          sh_c   = lsr_w[0];
        end
        2'b10: if (amt == 5'd0) begin  // ASR #32
          sh_res = {32{rm_data[31]}};
          sh_c   = rm_data[31];
        end else begin
          sh_res = asr_w[32:1];
          sh_c   = asr_w[0];
        end
        default: if (amt == 5'd0) begin  // RRX
          sh_res = {f_c, rm_data[31:1]};
          sh_c   = rm_data[0];
        end else begin
          sh_res = ror_w;
          sh_c   = ror_w[31];
        end
      endcase
    end
  end

  // Non-DP space, or the register-shifted-register form, is not supported.
  logic is_undef, is_logical, is_test;
  assign is_undef   = (ir_q[27:26] != 2'b00) || (!ir_q[25] && ir_q[4]);
  assign is_test    = (ir_q[24:23] == 2'b10);
  assign is_logical = (ir_q[24:22] == 3'b000) || (ir_q[24:23] == 2'b11) ||
                      (ir_q[24:22] == 3'b100);

  always_comb begin
    state_d     = state_q;
    ir_d        = ir_q;
    op1_d       = op1_q;
    op2_d       = op2_q;
    sh_c_d      = sh_c_q;
    rd_data_d   = rd_data_q;
    cpsr_d      = cpsr_q;
    rd_we_d     = 1'b0;
    cond_fail_d = 1'b0;
    undef_d     = 1'b0;
    case (state_q)
      S_IDLE: if (instr_valid) begin
        ir_d    = instr;
        state_d = S_READ;
      end
      S_READ: begin
        op1_d  = rn_data;
        op2_d  = sh_res;
        sh_c_d = sh_c;
        if (is_undef) begin
          undef_d = 1'b1;
          state_d = S_IDLE;
        end else if (!cond_pass) begin
          cond_fail_d = 1'b1;
          state_d     = S_IDLE;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        rd_data_d = alu_result;
        rd_we_d   = !is_test;
        if (ir_q[20]) begin
          if (is_logical) cpsr_d = {alu_n, alu_z, sh_c_q, f_v};
          else            cpsr_d = {alu_n, alu_z, alu_c, alu_v};
        end
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      ir_q        <= '0;
      op1_q       <= '0;
      op2_q       <= '0;
      sh_c_q      <= 1'b0;
      rd_data_q   <= '0;
      rd_we_q     <= 1'b0;
      cond_fail_q <= 1'b0;
      undef_q     <= 1'b0;
      cpsr_q      <= '0;
    end else begin
      state_q     <= state_d;
      ir_q        <= ir_d;
      op1_q       <= op1_d;
      op2_q       <= op2_d;
      sh_c_q      <= sh_c_d;
      rd_data_q   <= rd_data_d;
      rd_we_q     <= rd_we_d;
      cond_fail_q <= cond_fail_d;
      undef_q     <= undef_d;
      cpsr_q      <= cpsr_d;
    end
  end

endmodule

// File: tb/tb_dp_issue.sv
// Directed bench for dp_issue: a register-file model and an ALU model
// surround the DUT; expected writeback/status per instruction is queued at
// issue and popped when the DUT reaches the corresponding cycle.
module tb_dp_issue;

  logic        clk, rst_n, instr_valid, instr_ready;
  logic [31:0] instr, rn_data, rm_data, alu_operand1, alu_operand2, alu_result;
  logic [3:0]  rn_addr, rm_addr, alu_opcode, rd_addr, cpsr_nzcv;
  logic        alu_carry_in, alu_flag_update, alu_n, alu_z, alu_c, alu_v;
  logic        rd_we, cond_fail, undef;
  logic [31:0] rd_data;

  dp_issue dut (
    .clk(clk), .rst_n(rst_n),
    .instr_valid(instr_valid), .instr(instr), .instr_ready(instr_ready),
    .rn_addr(rn_addr), .rn_data(rn_data), .rm_addr(rm_addr), .rm_data(rm_data),
    .alu_opcode(alu_opcode), .alu_operand1(alu_operand1),
    .alu_operand2(alu_operand2), .alu_carry_in(alu_carry_in),
    .alu_flag_update(alu_flag_update), .alu_result(alu_result),
    .alu_n(alu_n), .alu_z(alu_z), .alu_c(alu_c), .alu_v(alu_v),
    .rd_we(rd_we), .rd_addr(rd_addr), .rd_data(rd_data),
    .cpsr_nzcv(cpsr_nzcv), .cond_fail(cond_fail), .undef(undef)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] regs [16];
  assign rn_data = regs[rn_addr];
  assign rm_data = regs[rm_addr];

  // Reference ALU: arithmetic ops become x + y + ci.
  logic [31:0] ax, ay, lres;
  logic        aci, arith;
  logic [32:0] asum;
  always_comb begin
    ax = alu_operand1; ay = alu_operand2; aci = 1'b0; arith = 1'b1;
    lres = 32'b0;
    case (alu_opcode)
      4'h0, 4'h8: begin lres = alu_operand1 & alu_operand2; arith = 1'b0; end
      4'h1, 4'h9: begin lres = alu_operand1 ^ alu_operand2; arith = 1'b0; end
      4'h2, 4'hA: begin ay = ~alu_operand2; aci = 1'b1; end
      4'h3: begin ax = alu_operand2; ay = ~alu_operand1; aci = 1'b1; end
      4'h4, 4'hB: ;
      4'h5: aci = alu_carry_in;
      4'h6: begin ay = ~alu_operand2; aci = alu_carry_in; end
      4'h7: begin ax = alu_operand2; ay = ~alu_operand1; aci = alu_carry_in; end
      4'hC: begin lres = alu_operand1 | alu_operand2; arith = 1'b0; end
      4'hD: begin lres = alu_operand2; arith = 1'b0; end
      4'hE: begin lres = alu_operand1 & ~alu_operand2; arith = 1'b0; end
      default: begin lres = ~alu_operand2; arith = 1'b0; end
    endcase
    asum       = {1'b0, ax} + {1'b0, ay} + {32'b0, aci};
    alu_result = arith ? asum[31:0] : lres;
    alu_c      = arith ? asum[32] : 1'b0;
    alu_v      = arith ? ((ax[31] == ay[31]) && (asum[31] != ax[31])) : 1'b0;
    alu_n      = alu_result[31];
    alu_z      = (alu_result == 32'b0);
  end

  typedef enum logic [1:0] {K_EXE, K_CF, K_UD} kind_e;
  typedef struct packed {
    kind_e       kind;
    logic        we;
    logic [3:0]  addr;
    logic [31:0] data;
    logic [3:0]  nzcv;
    logic [31:0] op2;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Called at a negedge in an IDLE cycle; returns at the negedge of cycle 3.
  task automatic issue(input string nm, input logic [31:0] ins, input exp_t e);
    exp_t x;
    chk({nm, ".ready0"}, 32'(instr_ready), 32'd1);
    sb.push_back(e);
    instr_valid = 1'b1;
    instr       = ins;
    @(negedge clk);                         // cycle 1: READ
    instr_valid = 1'b0;
    instr       = $urandom;
    chk({nm, ".ready1"}, 32'(instr_ready), 32'd0);
    @(negedge clk);                         // cycle 2: EXEC or status pulse
    x = sb.pop_front();
    chk({nm, ".cond_fail2"}, 32'(cond_fail), 32'(x.kind == K_CF));
    chk({nm, ".undef2"}, 32'(undef), 32'(x.kind == K_UD));
    chk({nm, ".rd_we2"}, 32'(rd_we), 32'd0);
    chk({nm, ".ready2"}, 32'(instr_ready), 32'(x.kind != K_EXE));
    if (x.kind == K_EXE) chk({nm, ".op2"}, alu_operand2, x.op2);
    @(negedge clk);                         // cycle 3: writeback visible
    chk({nm, ".rd_we3"}, 32'(rd_we), 32'(x.we));
    if (x.we) begin
      chk({nm, ".rd_addr"}, 32'(rd_addr), 32'(x.addr));
      chk({nm, ".rd_data"}, rd_data, x.data);
    end
    chk({nm, ".cpsr"}, 32'(cpsr_nzcv), 32'(x.nzcv));
    chk({nm, ".pulses3"}, 32'({cond_fail, undef}), 32'd0);
    chk({nm, ".ready3"}, 32'(instr_ready), 32'd1);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) regs[i] = 32'h0;
    regs[0] = 32'h7FFFFFFF;
    regs[1] = 32'h00000001;
    regs[5] = 32'h00000003;
    regs[9] = 32'h80000000;
    rst_n = 1'b0; instr_valid = 1'b0; instr = 32'h0;
    repeat (2) @(negedge clk);
    chk("rst.ready", 32'(instr_ready), 32'd1);
    chk("rst.outs", 32'({rd_we, cond_fail, undef, alu_carry_in, alu_flag_update}), 32'd0);
    chk("rst.cpsr", 32'(cpsr_nzcv), 32'd0);
    chk("rst.rd", rd_data | 32'(rd_addr), 32'd0);
    chk("rst.alu", alu_operand1 | alu_operand2 | 32'(alu_opcode), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    issue("mov_imm",  32'hE3A010FF, '{K_EXE, 1'b1, 4'd1, 32'h000000FF, 4'b0000, 32'h000000FF});
    issue("movs_rot", 32'hE3B034FF, '{K_EXE, 1'b1, 4'd3, 32'hFF000000, 4'b1010, 32'hFF000000});
    issue("adds",     32'hE0902001, '{K_EXE, 1'b1, 4'd2, 32'h80000000, 4'b1001, 32'h00000001});
    issue("moveq",    32'h03A01001, '{K_CF,  1'b0, 4'd0, 32'h0,        4'b1001, 32'h0});
    issue("cmp",      32'hE1500000, '{K_EXE, 1'b0, 4'd0, 32'h0,        4'b0110, 32'h7FFFFFFF});
    issue("ldr",      32'hE5901000, '{K_UD,  1'b0, 4'd0, 32'h0,        4'b0110, 32'h0});
    issue("ldr_nv",   32'hF5901000, '{K_UD,  1'b0, 4'd0, 32'h0,        4'b0110, 32'h0});
    issue("regshreg", 32'hE0802011, '{K_UD,  1'b0, 4'd0, 32'h0,        4'b0110, 32'h0});
    issue("movnv",    32'hF3A01001, '{K_CF,  1'b0, 4'd0, 32'h0,        4'b0110, 32'h0});
    issue("lsr32",    32'hE1B04025, '{K_EXE, 1'b1, 4'd4, 32'h00000000, 4'b0100, 32'h00000000});
    issue("rrx_c0",   32'hE1B06065, '{K_EXE, 1'b1, 4'd6, 32'h00000001, 4'b0010, 32'h00000001});
    issue("rrx_c1",   32'hE1B06065, '{K_EXE, 1'b1, 4'd6, 32'h80000001, 4'b1010, 32'h80000001});
    issue("lsl30",    32'hE1B07F05, '{K_EXE, 1'b1, 4'd7, 32'hC0000000, 4'b1000, 32'hC0000000});
    issue("asr32",    32'hE1B08049, '{K_EXE, 1'b1, 4'd8, 32'hFFFFFFFF, 4'b1010, 32'hFFFFFFFF});

    // ADDS abandoned by reset during EXEC.
    instr_valid = 1'b1; instr = 32'hE0902001;
    @(negedge clk);
    instr_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rstx.ready", 32'(instr_ready), 32'd1);
    chk("rstx.rd_we", 32'(rd_we), 32'd0);
    chk("rstx.cpsr", 32'(cpsr_nzcv), 32'd0);
    chk("rstx.rd", rd_data | 32'(rd_addr), 32'd0);
    chk("rstx.alu", alu_operand1 | alu_operand2 | 32'(alu_opcode), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rstx.rd_we_after", 32'(rd_we), 32'd0);
    chk("rstx.ready_after", 32'(instr_ready), 32'd1);
    chk("rstx.cpsr_after", 32'(cpsr_nzcv), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
